decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 if_id_instr_data  input  32  instruction from fetch, valid alongside if_id_pc.
REQ-004 if_id_pc  input  32  address of if_id_instr_data.
REQ-005 ex_if_branch_taken  input  1  EX redirect; the instruction currently in decode is wrong-path.
REQ-006 wb_id_rd_we / wb_id_rd_addr / wb_id_rd_data  input  1/5/32  register-file write port.
REQ-007 stall  output  1  combinational; when 1, fetch holds if_id_* unchanged.
REQ-008 id_ex_valid  output  1  id_ex_* carries a real instruction.
REQ-009 id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  output  32 each  registered decode results.
REQ-010 id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr  output  5 each  register indices.
REQ-011 id_ex_opcode, id_ex_funct3, id_ex_funct7b5  output  7/3/1  instr[6:0], [14:12], [30].
REQ-012 id_ex_reg_we, id_ex_mem_read, id_ex_illegal  output  1 each  control flags.

Function
REQ-013 All id_ex_* outputs SHALL be registered; latency if_id -> id_ex is exactly one clock.
REQ-014 Internal flag if_valid SHALL be 0 at reset and become 1 on the first clock edge after rst deasserts; while 0, id_ex_valid SHALL load 0.
REQ-015 Immediate: I-type (LOAD, OP-IMM, JALR) sext instr[31:20]; S sext {[31:25],[11:7]}; B sext {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J sext {[31],[19:12],[20],[30:21],0}; R-type and illegal imm=0.
REQ-016 rs1 is used by R, I, S, B, JALR, LOAD; rs2 by R, S, B; LUI, AUIPC, JAL use none.
REQ-017 id_ex_reg_we=1 for R, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR when rd!=0; else 0.
REQ-018 id_ex_mem_read=1 only for LOAD.
REQ-019 Unknown opcodes SHALL set id_ex_illegal=1 with reg_we=0, mem_read=0; id_ex_valid is unaffected.
REQ-020 Load-use hazard: stall=1 when id_ex_valid & id_ex_mem_read & id_ex_rd_addr!=0 & (rd==rs1 and rs1 used, or rd==rs2 and rs2 used) & if_valid & !ex_if_branch_taken.
REQ-021 On a stall edge, id_ex_valid SHALL load 0 (bubble) and decode input is re-presented next cycle; stall clears after exactly one cycle.
REQ-022 On ex_if_branch_taken=1, id_ex_valid SHALL load 0 on that edge; flush takes priority over stall.
REQ-023 Register file: 32x32; x0 reads 0 and writes to x0 are ignored; write on posedge when wb_id_rd_we.
REQ-024 Reads SHALL be combinational with write-through: same-cycle write to the read index returns wb_id_rd_data.
REQ-025 When id_ex_valid loads 0, the other id_ex_* fields are don't-care, except id_ex_reg_we and id_ex_mem_read, which SHALL be 0.

Reset
REQ-026 rst SHALL asynchronously clear all id_ex_* outputs, if_valid, and all 32 registers to 0.
REQ-027 Reset mid-operation SHALL discard any pending stall; stall SHALL read 0 while rst is high.

Structure
REQ-028 Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) SHALL live in package rv_pkg.
REQ-029 Register file SHALL be sub-module register_file (2 read ports, 1 write port, bypass inside).
REQ-030 Immediate generation and hazard detection SHALL stay in decode_stage.

Verification
REQ-031 Write x5=0x12345678, then present 0x00128313 (addi x6,x5,1) -> next cycle rs1_data=0x12345678, imm=1, rd=6, reg_we=1, valid=1.
REQ-032 id_ex holds lw x7 (valid); decode add x8,x7,x1 -> stall=1 for one cycle, id_ex_valid=0 once, then add issues with rs1_addr=7.
REQ-033 ex_if_branch_taken=1 while decode holds any instruction -> id_ex_valid=0 next cycle, stall=0.
REQ-034 Write x0=0xFFFFFFFF, read x0 -> rs1_data=0; same-cycle write x3=0xA5A5A5A5 while decoding rs1=x3 -> rs1_data=0xA5A5A5A5.
REQ-035 Present 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, reg_we=0; present 0xFFFFFFFF -> illegal=1.
REQ-036 Assert rst during an active stall -> all outputs 0 asynchronously; first post-reset cycle id_ex_valid=0.

Source files
------------

// File: rtl/rv_pkg.sv
// RV32I opcode constants and the per-opcode control decode shared by the decode stage.
// Immediate generation and hazard logic live in decode_stage itself.
package rv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_e;

    typedef struct packed {
        fmt_e fmt;
        logic rs1_used;
        logic rs2_used;
        logic writes_rd;
        logic mem_read;
        logic illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c.fmt       = FMT_X;
        c.rs1_used  = 1'b0;
        c.rs2_used  = 1'b0;
        c.writes_rd = 1'b0;
        c.mem_read  = 1'b0;
        c.illegal   = 1'b0;
        case (opcode)
            OP: begin
                c.fmt       = FMT_R;
                c.rs1_used  = 1'b1;
                c.rs2_used  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OP_IMM: begin
                c.fmt       = FMT_I;
                c.rs1_used  = 1'b1;
                c.writes_rd = 1'b1;
            end
            LOAD: begin
                c.fmt       = FMT_I;
                c.rs1_used  = 1'b1;
                c.writes_rd = 1'b1;
                c.mem_read  = 1'b1;
            end
            JALR: begin
                c.fmt       = FMT_I;
                c.rs1_used  = 1'b1;
                c.writes_rd = 1'b1;
            end
            STORE: begin
                c.fmt      = FMT_S;
                c.rs1_used = 1'b1;
                c.rs2_used = 1'b1;
            end
            BRANCH: begin
                c.fmt      = FMT_B;
                c.rs1_used = 1'b1;
                c.rs2_used = 1'b1;
            end
            LUI, AUIPC: begin
                c.fmt       = FMT_U;
                c.writes_rd = 1'b1;
            end
            JAL: begin
                c.fmt       = FMT_J;
                c.writes_rd = 1'b1;
            end
            default: begin
                c.fmt     = FMT_X;
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 integer register file: two combinational read ports with write-through, one write port.
// x0 is hardwired to zero; writes to it are dropped.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_rd_we,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data
);

    logic [31:0] r_regs [32];
    logic        w_wr_en;

    assign w_wr_en = i_rd_we & (i_rd_addr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_wr_en) begin
            r_regs[i_rd_addr] <= i_rd_data;
        end
    end

    // Bypass lets an instruction in decode see the writeback landing on the same edge.
    always_comb begin
        o_rs1_data = r_regs[i_rs1_addr];
        if (i_rs1_addr == 5'd0) begin
            o_rs1_data = 32'd0;
        end else if (w_wr_en && (i_rd_addr == i_rs1_addr)) begin
            o_rs1_data = i_rd_data;
        end
    end

    always_comb begin
        o_rs2_data = r_regs[i_rs2_addr];
        if (i_rs2_addr == 5'd0) begin
            o_rs2_data = 32'd0;
        end else if (w_wr_en && (i_rd_addr == i_rs2_addr)) begin
            o_rs2_data = i_rd_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, immediate generation, load-use hazard detection,
// branch flush and the registered ID/EX pipeline boundary.
module decode_stage
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_instr_data,
    input  logic [31:0] if_id_pc,
    input  logic        ex_if_branch_taken,
    input  logic        wb_id_rd_we,
    input  logic [4:0]  wb_id_rd_addr,
    input  logic [31:0] wb_id_rd_data,
    output logic        stall,
    output logic        id_ex_valid,
    output logic [31:0] id_ex_pc,
    output logic [31:0] id_ex_rs1_data,
    output logic [31:0] id_ex_rs2_data,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rs1_addr,
    output logic [4:0]  id_ex_rs2_addr,
    output logic [4:0]  id_ex_rd_addr,
    output logic [6:0]  id_ex_opcode,
    output logic [2:0]  id_ex_funct3,
    output logic        id_ex_funct7b5,
    output logic        id_ex_reg_we,
    output logic        id_ex_mem_read,
    output logic        id_ex_illegal
);

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    ctrl_t       w_ctrl;
    logic        w_reg_we;
    logic        w_hazard;
    logic        w_stall;
    logic        w_load;

    logic        r_if_valid;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1_addr;
    logic [4:0]  r_rs2_addr;
    logic [4:0]  r_rd_addr;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic        r_funct7b5;
    logic        r_reg_we;
    logic        r_mem_read;
    logic        r_illegal;

    assign w_instr  = if_id_instr_data;
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_ctrl   = decode_ctrl(w_opcode);
    assign w_reg_we = w_ctrl.writes_rd & (w_rd != 5'd0);

    always_comb begin
        w_imm = 32'd0;
        case (w_ctrl.fmt)
            FMT_I:   w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            FMT_S:   w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            FMT_B:   w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                              w_instr[30:25], w_instr[11:8], 1'b0};
            FMT_U:   w_imm = {w_instr[31:12], 12'd0};
            FMT_J:   w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                              w_instr[20], w_instr[30:21], 1'b0};
            default: w_imm = 32'd0;
        endcase
    end

    register_file u_register_file (
        .clk        (clk),
        .rst        (rst),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_rd_we    (wb_id_rd_we),
        .i_rd_addr  (wb_id_rd_addr),
        .i_rd_data  (wb_id_rd_data)
    );

    // A load in EX whose result decode needs cannot be forwarded in time; insert one bubble.
    assign w_hazard = r_valid & r_mem_read & (r_rd_addr != 5'd0) &
                      (((r_rd_addr == w_rs1) & w_ctrl.rs1_used) |
                       ((r_rd_addr == w_rs2) & w_ctrl.rs2_used));
    assign w_stall  = w_hazard & r_if_valid & ~ex_if_branch_taken & ~rst;
    assign stall    = w_stall;

    assign w_load   = r_if_valid & ~ex_if_branch_taken & ~w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_rs1_data <= 32'd0;
            r_rs2_data <= 32'd0;
            r_imm      <= 32'd0;
            r_rs1_addr <= 5'd0;
            r_rs2_addr <= 5'd0;
            r_rd_addr  <= 5'd0;
            r_opcode   <= 7'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_reg_we   <= 1'b0;
            r_mem_read <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_if_valid <= 1'b1;
            r_valid    <= w_load;
            r_pc       <= if_id_pc;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_imm      <= w_imm;
            r_rs1_addr <= w_rs1;
            r_rs2_addr <= w_rs2;
            r_rd_addr  <= w_rd;
            r_opcode   <= w_opcode;
            r_funct3   <= w_instr[14:12];
            r_funct7b5 <= w_instr[30];
            r_reg_we   <= w_load & w_reg_we;
            r_mem_read <= w_load & w_ctrl.mem_read;
            r_illegal  <= w_ctrl.illegal;
        end
    end

    assign id_ex_valid    = r_valid;
    assign id_ex_pc       = r_pc;
    assign id_ex_rs1_data = r_rs1_data;
    assign id_ex_rs2_data = r_rs2_data;
    assign id_ex_imm      = r_imm;
    assign id_ex_rs1_addr = r_rs1_addr;
    assign id_ex_rs2_addr = r_rs2_addr;
    assign id_ex_rd_addr  = r_rd_addr;
    assign id_ex_opcode   = r_opcode;
    assign id_ex_funct3   = r_funct3;
    assign id_ex_funct7b5 = r_funct7b5;
    assign id_ex_reg_we   = r_reg_we;
    assign id_ex_mem_read = r_mem_read;
    assign id_ex_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares on every id_ex_valid.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_id_instr_data = 32'h0000_0013;
    logic [31:0] if_id_pc = 32'd0;
    logic        ex_if_branch_taken = 1'b0;
    logic        wb_id_rd_we = 1'b0;
    logic [4:0]  wb_id_rd_addr = 5'd0;
    logic [31:0] wb_id_rd_data = 32'd0;
    logic        stall;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr;
    logic [6:0]  id_ex_opcode;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_funct7b5, id_ex_reg_we, id_ex_mem_read, id_ex_illegal;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        chk2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1a;
        logic        we;
        logic        mr;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    decode_stage dut (
        .clk                (clk),
        .rst                (rst),
        .if_id_instr_data   (if_id_instr_data),
        .if_id_pc           (if_id_pc),
        .ex_if_branch_taken (ex_if_branch_taken),
        .wb_id_rd_we        (wb_id_rd_we),
        .wb_id_rd_addr      (wb_id_rd_addr),
        .wb_id_rd_data      (wb_id_rd_data),
        .stall              (stall),
        .id_ex_valid        (id_ex_valid),
        .id_ex_pc           (id_ex_pc),
        .id_ex_rs1_data     (id_ex_rs1_data),
        .id_ex_rs2_data     (id_ex_rs2_data),
        .id_ex_imm          (id_ex_imm),
        .id_ex_rs1_addr     (id_ex_rs1_addr),
        .id_ex_rs2_addr     (id_ex_rs2_addr),
        .id_ex_rd_addr      (id_ex_rd_addr),
        .id_ex_opcode       (id_ex_opcode),
        .id_ex_funct3       (id_ex_funct3),
        .id_ex_funct7b5     (id_ex_funct7b5),
        .id_ex_reg_we       (id_ex_reg_we),
        .id_ex_mem_read     (id_ex_mem_read),
        .id_ex_illegal      (id_ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && id_ex_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_issue: pc 0x%08h issued with empty scoreboard", id_ex_pc);
            end else begin
                e = q.pop_front();
                chk("pc",       id_ex_pc,                e.pc);
                chk("rs1_data", id_ex_rs1_data,          e.rs1d);
                if (e.chk2) chk("rs2_data", id_ex_rs2_data, e.rs2d);
                chk("imm",      id_ex_imm,               e.imm);
                chk("rd_addr",  {27'd0, id_ex_rd_addr},  {27'd0, e.rd});
                chk("rs1_addr", {27'd0, id_ex_rs1_addr}, {27'd0, e.rs1a});
                chk("reg_we",   {31'd0, id_ex_reg_we},   {31'd0, e.we});
                chk("mem_read", {31'd0, id_ex_mem_read}, {31'd0, e.mr});
                chk("illegal",  {31'd0, id_ex_illegal},  {31'd0, e.ill});
            end
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic br,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #2;
        if_id_instr_data   = instr;
        if_id_pc           = pc;
        ex_if_branch_taken = br;
        wb_id_rd_we        = we;
        wb_id_rd_addr      = wa;
        wb_id_rd_data      = wd;
    endtask

    task automatic expect_issue(input logic [31:0] pc, input logic [31:0] rs1d,
                                input logic [31:0] rs2d, input logic chk2,
                                input logic [31:0] imm, input logic [4:0] rd,
                                input logic [4:0] rs1a, input logic we,
                                input logic mr, input logic ill);
        exp_t e;
        e.pc = pc; e.rs1d = rs1d; e.rs2d = rs2d; e.chk2 = chk2; e.imm = imm;
        e.rd = rd; e.rs1a = rs1a; e.we = we; e.mr = mr; e.ill = ill;
        q.push_back(e);
    endtask

    task automatic mid_cycle;
        @(negedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADDI_6_5 = 32'h0012_8313;
    localparam logic [31:0] ADD_10   = 32'h0010_0533;
    localparam logic [31:0] ADDI_4_3 = 32'h0051_8213;
    localparam logic [31:0] LW_7     = 32'h0000_A383;
    localparam logic [31:0] ADD_8    = 32'h0013_8433;
    localparam logic [31:0] BEQ_M4   = 32'hFE00_0EE3;
    localparam logic [31:0] ILLEGAL  = 32'hFFFF_FFFF;
    localparam logic [31:0] LUI_12   = 32'hABCD_E637;
    localparam logic [31:0] JAL_1    = 32'h0080_00EF;
    localparam logic [31:0] SW_1_2   = 32'h0011_2623;

    initial begin
        #12;
        chk("reset_valid",    {31'd0, id_ex_valid},    32'd0);
        chk("reset_stall",    {31'd0, stall},          32'd0);
        chk("reset_reg_we",   {31'd0, id_ex_reg_we},   32'd0);
        chk("reset_mem_read", {31'd0, id_ex_mem_read}, 32'd0);
        #10 rst = 1'b0;

        // first post-reset edge only raises if_valid
        drive(NOP, 32'h00, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
        expect_issue(32'h00, 32'd0, 32'd0, 1'b1, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        mid_cycle();
        chk("first_cycle_valid", {31'd0, id_ex_valid}, 32'd0);

        drive(ADDI_6_5, 32'h04, 1'b0, 1'b1, 5'd1, 32'h0000_0011);
        expect_issue(32'h04, 32'h1234_5678, 32'd0, 1'b0, 32'd1, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0);

        drive(NOP, 32'h08, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        expect_issue(32'h08, 32'd0, 32'd0, 1'b1, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        drive(ADD_10, 32'h0C, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h0C, 32'd0, 32'h11, 1'b1, 32'd0, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);

        drive(ADDI_4_3, 32'h10, 1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5);
        expect_issue(32'h10, 32'hA5A5_A5A5, 32'd0, 1'b0, 32'd5, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0);

        // load-use: one bubble, then the dependent add issues from the held fetch
        drive(LW_7, 32'h14, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h14, 32'h11, 32'd0, 1'b0, 32'd0, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0);
        drive(ADD_8, 32'h18, 1'b0, 1'b0, 5'd0, 32'd0);
        mid_cycle();
        chk("loaduse_stall", {31'd0, stall}, 32'd1);
        drive(ADD_8, 32'h18, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h18, 32'd0, 32'h11, 1'b1, 32'd0, 5'd8, 5'd7, 1'b1, 1'b0, 1'b0);
        mid_cycle();
        chk("bubble_valid",   {31'd0, id_ex_valid}, 32'd0);
        chk("stall_cleared",  {31'd0, stall},       32'd0);
        chk("bubble_reg_we",  {31'd0, id_ex_reg_we}, 32'd0);

        // flush beats a pending load-use stall
        drive(LW_7, 32'h1C, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h1C, 32'h11, 32'd0, 1'b0, 32'd0, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0);
        drive(ADD_8, 32'h20, 1'b1, 1'b0, 5'd0, 32'd0);
        mid_cycle();
        chk("flush_stall", {31'd0, stall}, 32'd0);

        drive(BEQ_M4, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h100, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFC, 5'd29, 5'd0, 1'b0, 1'b0, 1'b0);
        mid_cycle();
        chk("flush_valid",    {31'd0, id_ex_valid},    32'd0);
        chk("flush_mem_read", {31'd0, id_ex_mem_read}, 32'd0);

        drive(ILLEGAL, 32'h104, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h104, 32'd0, 32'd0, 1'b0, 32'd0, 5'd31, 5'd31, 1'b0, 1'b0, 1'b1);
        drive(LUI_12, 32'h108, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h108, 32'd0, 32'd0, 1'b0, 32'hABCD_E000, 5'd12, 5'd27, 1'b1, 1'b0, 1'b0);
        drive(JAL_1, 32'h10C, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h10C, 32'd0, 32'd0, 1'b0, 32'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        drive(SW_1_2, 32'h110, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h110, 32'd0, 32'h11, 1'b1, 32'd12, 5'd12, 5'd2, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a stall
        drive(LW_7, 32'h200, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h200, 32'h11, 32'd0, 1'b0, 32'd0, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0);
        drive(ADD_8, 32'h204, 1'b0, 1'b0, 5'd0, 32'd0);
        mid_cycle();
        chk("pre_reset_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid",    {31'd0, id_ex_valid},    32'd0);
        chk("async_rst_stall",    {31'd0, stall},          32'd0);
        chk("async_rst_reg_we",   {31'd0, id_ex_reg_we},   32'd0);
        chk("async_rst_mem_read", {31'd0, id_ex_mem_read}, 32'd0);
        chk("async_rst_rs1_data", id_ex_rs1_data,          32'd0);
        chk("async_rst_imm",      id_ex_imm,               32'd0);
        #1 rst = 1'b0;
        drive(NOP, 32'h300, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h300, 32'd0, 32'd0, 1'b1, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        mid_cycle();
        chk("post_reset_valid", {31'd0, id_ex_valid}, 32'd0);
        drive(ADDI_6_5, 32'h304, 1'b0, 1'b0, 5'd0, 32'd0);
        expect_issue(32'h304, 32'd0, 32'd0, 1'b0, 32'd1, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0);

        // drain: flush keeps further issues out of the scoreboard
        drive(NOP, 32'h308, 1'b1, 1'b0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        mid_cycle();
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
